// File: rtl/enemy_ctrl_pkg.sv
// Shared types for the enemy controller: action codes, FSM states, probe coordinates.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package enemy_ctrl_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_LEFT  = 3'd1,
        ACT_RIGHT = 3'd2,
        ACT_DOWN  = 3'd3,
        ACT_UP    = 3'd4
    } action_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_PROBE0 = 3'd2,
        ST_PROBE1 = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DEAD   = 3'd5
    } state_t;

    // One level-ROM probe address.
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } coord_t;

    // AI action code to direction; the unused codes 5-7 mean "stand still".
    function automatic action_t decode_action(input logic [2:0] code);
        action_t d;
        case (code)
            3'd1:    d = ACT_LEFT;
            3'd2:    d = ACT_RIGHT;
            3'd3:    d = ACT_DOWN;
            3'd4:    d = ACT_UP;
            default: d = ACT_NONE;
        endcase
        return d;
    endfunction

    // Knockback pushes the enemy opposite to the way it was travelling.
    function automatic action_t reverse_dir(input action_t d);
        action_t r;
        case (d)
            ACT_LEFT:  r = ACT_RIGHT;
            ACT_RIGHT: r = ACT_LEFT;
            ACT_DOWN:  r = ACT_UP;
            ACT_UP:    r = ACT_DOWN;
            default:   r = ACT_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/enemy_ctrl_if.sv
// Bundle of control, level-ROM probe and status signals between an enemy and its surroundings.
// Latency: n/a (wires only).
// Backpressure: none; every signal is a level or a 1-Clk pulse.
interface enemy_ctrl_if #(
    parameter int HP_MAX = 3
) ();
    localparam int HPW = $clog2(HP_MAX + 1);

    logic           spawn;
    logic [9:0]     spawn_x;
    logic [9:0]     spawn_y;
    logic [2:0]     room;
    logic [2:0]     action;
    logic           damage;
    logic [9:0]     probe_x;
    logic [9:0]     probe_y;
    logic           probe_wall;
    logic [9:0]     Enemy_X;
    logic [9:0]     Enemy_Y;
    logic           active;
    logic [HPW-1:0] hp;
    logic           hit_ack;

    // Enemy controller side.
    modport slave (
        input  spawn, spawn_x, spawn_y, room, action, damage, probe_wall,
        output probe_x, probe_y, Enemy_X, Enemy_Y, active, hp, hit_ack
    );

    // Game-logic / level-ROM side.
    modport master (
        output spawn, spawn_x, spawn_y, room, action, damage, probe_wall,
        input  probe_x, probe_y, Enemy_X, Enemy_Y, active, hp, hit_ack
    );
endinterface

// File: rtl/enemy_ctrl_edge_det.sv
// Synchronises an asynchronous level into Clk and flags its rising edge.
// Latency: rise_o is high for the single Clk that starts 2 Clk after sig_i rises.
// Backpressure: none; the pulse is lost if the consumer is busy.
module edge_det (
    input  logic Clk,
    input  logic Reset_n,
    input  logic sig_i,
    output logic rise_o
);
    logic sync0_q;
    logic sync1_q;
    logic prev_q;

    // Two-flop synchroniser followed by a delay flop for edge detection.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync0_q <= sig_i;
            sync1_q <= sync0_q;
            prev_q  <= sync1_q;
        end
    end

    assign rise_o = sync1_q & ~prev_q;
endmodule

// File: rtl/enemy_ctrl.sv
// Per-enemy movement/health controller: wall-checked stepping, hits, knockback, invulnerability.
// Latency: position commits 4 Clk after the synchronised frame-edge pulse rises; hit_ack 1 Clk after damage.
// Backpressure: none; frame edges arriving mid-probe are dropped, never queued.
module enemy_ctrl #(
    parameter int SIZE         = 32,
    parameter int STEP         = 2,
    parameter int KNOCK_STEP   = 4,
    parameter int KNOCK_FRAMES = 8,
    parameter int INVULN_FRM   = 16,
    parameter int HP_MAX       = 3,
    parameter int X_OFF        = 700,
    parameter int Y_OFF        = 600
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         frame_clk,
    enemy_ctrl_if.slave  bus
);
    import enemy_ctrl_pkg::*;

    localparam int HPW = $clog2(HP_MAX + 1);
    localparam int KW  = $clog2(KNOCK_FRAMES + 1);
    localparam int IW  = $clog2(INVULN_FRM + 1);

    localparam logic signed [10:0] X_MAX    = 11'(SCREEN_W - SIZE);
    localparam logic signed [10:0] Y_MAX    = 11'(SCREEN_H - SIZE);
    localparam logic signed [10:0] STEP_V   = 11'(STEP);
    localparam logic signed [10:0] KSTEP_V  = 11'(KNOCK_STEP);
    localparam logic [9:0]         EDGE_OFF = 10'(SIZE - 1);
    localparam logic [9:0]         PARK_X   = 10'(X_OFF);
    localparam logic [9:0]         PARK_Y   = 10'(Y_OFF);

    // Registered state and outputs
    state_t         state_q;
    logic [9:0]     x_q;
    logic [9:0]     y_q;
    logic           active_q;
    logic [HPW-1:0] hp_q;
    logic           hit_ack_q;
    coord_t         probe_q;
    coord_t         probe1_q;      // second corner, issued the Clk after the first
    logic [KW-1:0]  knock_q;
    logic [IW-1:0]  inv_q;
    action_t        dir_q;         // direction of the last started move
    action_t        knock_dir_q;   // direction knockback pushes in
    logic [9:0]     cand_x_q;
    logic [9:0]     cand_y_q;
    logic           oob_q;
    logic           wall0_q;
    logic [2:0]     room_q;

    // Combinational next-move evaluation
    logic              frame_edge;
    logic              room_chg;
    logic              dmg_ok;
    logic              fatal;
    logic [KW-1:0]     knock_eff;
    logic [KW-1:0]     knock_nx;
    logic [IW-1:0]     inv_eff;
    logic [IW-1:0]     inv_nx;
    action_t           kdir_eff;
    action_t           move_dir;
    logic signed [10:0] step;
    logic signed [10:0] vec_x;
    logic signed [10:0] vec_y;
    logic signed [10:0] cand_x;
    logic signed [10:0] cand_y;
    logic              oob;
    coord_t            c0;
    coord_t            c1;

    edge_det u_frame_edge (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .sig_i   (frame_clk),
        .rise_o  (frame_edge)
    );

    assign room_chg = (bus.room != room_q);

    // A hit is folded in before the frame edge so a simultaneous edge already sees the new knockback.
    always_comb begin
        dmg_ok    = bus.damage & active_q & (inv_q == '0);
        fatal     = dmg_ok & (hp_q == HPW'(1));
        knock_eff = dmg_ok ? KW'(KNOCK_FRAMES) : knock_q;
        inv_eff   = dmg_ok ? IW'(INVULN_FRM) : inv_q;
        kdir_eff  = dmg_ok ? reverse_dir(dir_q) : knock_dir_q;

        knock_nx = knock_eff;
        if (frame_edge && (knock_eff != '0)) begin
            knock_nx = knock_eff - KW'(1);
        end
        inv_nx = inv_eff;
        if (frame_edge && (inv_eff != '0)) begin
            inv_nx = inv_eff - IW'(1);
        end

        if (knock_eff != '0) begin
            move_dir = kdir_eff;
            step     = KSTEP_V;
        end else begin
            move_dir = decode_action(bus.action);
            step     = STEP_V;
        end

        vec_x = '0;
        vec_y = '0;
        case (move_dir)
            ACT_LEFT:  vec_x = -step;
            ACT_RIGHT: vec_x = step;
            ACT_DOWN:  vec_y = step;
            ACT_UP:    vec_y = -step;
            default:   ;
        endcase

        cand_x = $signed({1'b0, x_q}) + vec_x;
        cand_y = $signed({1'b0, y_q}) + vec_y;
        oob    = cand_x[10] | (cand_x > X_MAX) | cand_y[10] | (cand_y > Y_MAX);

        // Leading corners of the candidate sprite box for the chosen direction.
        c0 = '{x: cand_x[9:0], y: cand_y[9:0]};
        c1 = c0;
        case (move_dir)
            ACT_LEFT: begin
                c1.y = cand_y[9:0] + EDGE_OFF;
            end
            ACT_RIGHT: begin
                c0.x = cand_x[9:0] + EDGE_OFF;
                c1.x = cand_x[9:0] + EDGE_OFF;
                c1.y = cand_y[9:0] + EDGE_OFF;
            end
            ACT_DOWN: begin
                c0.y = cand_y[9:0] + EDGE_OFF;
                c1.x = cand_x[9:0] + EDGE_OFF;
                c1.y = cand_y[9:0] + EDGE_OFF;
            end
            ACT_UP: begin
                c1.x = cand_x[9:0] + EDGE_OFF;
            end
            default: ;
        endcase
    end

    assign bus.probe_x = probe_q.x;
    assign bus.probe_y = probe_q.y;
    assign bus.Enemy_X = x_q;
    assign bus.Enemy_Y = y_q;
    assign bus.active  = active_q;
    assign bus.hp      = hp_q;
    assign bus.hit_ack = hit_ack_q;

    // Main FSM: spawn beats room change, room change beats everything else, death abandons any probe.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            x_q         <= PARK_X;
            y_q         <= PARK_Y;
            active_q    <= 1'b0;
            hp_q        <= '0;
            hit_ack_q   <= 1'b0;
            probe_q     <= '0;
            probe1_q    <= '0;
            knock_q     <= '0;
            inv_q       <= '0;
            dir_q       <= ACT_NONE;
            knock_dir_q <= ACT_NONE;
            cand_x_q    <= '0;
            cand_y_q    <= '0;
            oob_q       <= 1'b0;
            wall0_q     <= 1'b0;
            room_q      <= '0;
        end else begin
            hit_ack_q <= 1'b0;
            room_q    <= bus.room;

            if (bus.spawn) begin
                state_q     <= ST_WAIT;
                x_q         <= bus.spawn_x;
                y_q         <= bus.spawn_y;
                active_q    <= 1'b1;
                hp_q        <= HPW'(HP_MAX);
                knock_q     <= '0;
                inv_q       <= '0;
                dir_q       <= ACT_NONE;
                knock_dir_q <= ACT_NONE;
            end else if (room_chg) begin
                state_q  <= ST_IDLE;
                x_q      <= PARK_X;
                y_q      <= PARK_Y;
                active_q <= 1'b0;
                hp_q     <= '0;
                knock_q  <= '0;
                inv_q    <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_DEAD: begin
                        state_q <= ST_IDLE;
                        x_q     <= PARK_X;
                        y_q     <= PARK_Y;
                    end
                    default: begin
                        if (fatal) begin
                            state_q   <= ST_DEAD;
                            hp_q      <= '0;
                            active_q  <= 1'b0;
                            hit_ack_q <= 1'b1;
                            knock_q   <= '0;
                            inv_q     <= '0;
                        end else begin
                            if (dmg_ok) begin
                                hp_q        <= hp_q - HPW'(1);
                                hit_ack_q   <= 1'b1;
                                knock_dir_q <= kdir_eff;
                            end
                            knock_q <= knock_nx;
                            inv_q   <= inv_nx;

                            case (state_q)
                                ST_WAIT: begin
                                    if (frame_edge && (move_dir != ACT_NONE)) begin
                                        state_q  <= ST_PROBE0;
                                        dir_q    <= move_dir;
                                        cand_x_q <= cand_x[9:0];
                                        cand_y_q <= cand_y[9:0];
                                        oob_q    <= oob;
                                        probe1_q <= c1;
                                        // Off-screen candidates never reach the ROM.
                                        if (!oob) begin
                                            probe_q <= c0;
                                        end
                                    end
                                end
                                ST_PROBE0: begin
                                    state_q <= ST_PROBE1;
                                    if (!oob_q) begin
                                        probe_q <= probe1_q;
                                    end
                                end
                                ST_PROBE1: begin
                                    state_q <= ST_CHECK;
                                    wall0_q <= bus.probe_wall;
                                end
                                ST_CHECK: begin
                                    state_q <= ST_WAIT;
                                    if (!(oob_q | wall0_q | bus.probe_wall)) begin
                                        x_q <= cand_x_q;
                                        y_q <= cand_y_q;
                                    end
                                end
                                default: state_q <= ST_IDLE;
                            endcase
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_enemy_ctrl.sv
// Directed bench for enemy_ctrl: movement, wall/edge blocking, hits, death, room change, async reset.
// Latency: frame_clk is raised just after a Clk edge; the move lands 6 Clk later (2 sync + 4 FSM).
// Backpressure: n/a.
module tb_enemy_ctrl;
    import enemy_ctrl_pkg::*;

    logic Clk = 1'b0;
    logic Reset_n;
    logic frame_clk;
    logic wall_en;

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] probe_log[$];
    logic [9:0]  last_px = '0;
    logic [9:0]  last_py = '0;

    always #5 Clk = ~Clk;

    enemy_ctrl_if bus ();

    enemy_ctrl dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    // Registered level-ROM model: a vertical wall column at x=98 when enabled.
    always @(posedge Clk) begin
        bus.probe_wall <= wall_en & (bus.probe_x == 10'd98);
    end

    // Record every new probe address the DUT presents.
    always @(negedge Clk) begin
        if (bus.probe_x != last_px || bus.probe_y != last_py) begin
            probe_log.push_back({bus.probe_x, bus.probe_y});
            last_px = bus.probe_x;
            last_py = bus.probe_y;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_frame();
        @(negedge Clk);
        frame_clk = 1'b1;
        tick(6);
        frame_clk = 1'b0;
        tick(4);
    endtask

    task automatic do_spawn(input logic [9:0] sx, input logic [9:0] sy);
        @(negedge Clk);
        bus.spawn   = 1'b1;
        bus.spawn_x = sx;
        bus.spawn_y = sy;
        @(negedge Clk);
        bus.spawn   = 1'b0;
    endtask

    task automatic hit();
        @(negedge Clk);
        bus.damage = 1'b1;
        @(negedge Clk);
        bus.damage = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "bench did not complete");
    end

    initial begin
        logic [19:0] e0;
        logic [19:0] e1;

        Reset_n     = 1'b0;
        frame_clk   = 1'b0;
        wall_en     = 1'b0;
        bus.spawn   = 1'b0;
        bus.spawn_x = '0;
        bus.spawn_y = '0;
        bus.room    = 3'd0;
        bus.action  = 3'd0;
        bus.damage  = 1'b0;
        tick(3);
        Reset_n = 1'b1;
        tick(2);

        // Reset state
        check_val("rst_x", bus.Enemy_X, 700);
        check_val("rst_y", bus.Enemy_Y, 600);
        check_val("rst_active", bus.active, 0);
        check_val("rst_hp", bus.hp, 0);
        check_val("rst_hit_ack", bus.hit_ack, 0);
        check_val("rst_probe_x", bus.probe_x, 0);
        check_val("rst_probe_y", bus.probe_y, 0);

        // 1: open floor, move left three frames, with exact commit timing on the first
        bus.action = 3'd1;
        do_spawn(10'd100, 10'd100);
        check_val("t1_active", bus.active, 1);
        check_val("t1_hp", bus.hp, 3);
        check_val("t1_spawn_x", bus.Enemy_X, 100);
        @(negedge Clk);
        frame_clk = 1'b1;
        tick(5);
        check_val("t1_precommit_x", bus.Enemy_X, 100);
        tick(1);
        check_val("t1_commit_x", bus.Enemy_X, 98);
        frame_clk = 1'b0;
        tick(4);
        do_frame();
        do_frame();
        check_val("t1_x", bus.Enemy_X, 94);
        check_val("t1_y", bus.Enemy_Y, 100);

        // 2: wall column at x=98 blocks a left step; both left corners are probed
        wall_en = 1'b1;
        do_spawn(10'd100, 10'd100);
        probe_log.delete();
        do_frame();
        check_val("t2_x", bus.Enemy_X, 100);
        check_val("t2_nprobes", probe_log.size(), 2);
        e0 = (probe_log.size() > 0) ? probe_log[0] : '1;
        e1 = (probe_log.size() > 1) ? probe_log[1] : '1;
        check_val("t2_probe0", e0, {10'd98, 10'd100});
        check_val("t2_probe1", e1, {10'd98, 10'd131});
        wall_en = 1'b0;

        // 3: screen edges block without probing
        bus.action = 3'd1;
        do_spawn(10'd0, 10'd50);
        probe_log.delete();
        do_frame();
        check_val("t3_left_x", bus.Enemy_X, 0);
        check_val("t3_left_nprobes", probe_log.size(), 0);
        bus.action = 3'd2;
        do_spawn(10'd608, 10'd50);
        probe_log.delete();
        do_frame();
        check_val("t3_right_x", bus.Enemy_X, 608);
        check_val("t3_right_y", bus.Enemy_Y, 50);
        check_val("t3_right_nprobes", probe_log.size(), 0);

        // 4: hit while moving right -> 8 frames of 4 px knockback left, rehit ignored
        bus.action = 3'd2;
        do_spawn(10'd196, 10'd100);
        do_frame();
        do_frame();
        check_val("t4_start_x", bus.Enemy_X, 200);
        hit();
        check_val("t4_hit_ack", bus.hit_ack, 1);
        check_val("t4_hp", bus.hp, 2);
        tick(1);
        check_val("t4_hit_ack_pulse", bus.hit_ack, 0);
        for (int k = 1; k <= 8; k++) begin
            do_frame();
            check_val($sformatf("t4_knock_x%0d", k), bus.Enemy_X, 200 - 4 * k);
            if (k == 5) begin
                hit();
                check_val("t4_invuln_ack", bus.hit_ack, 0);
                check_val("t4_invuln_hp", bus.hp, 2);
            end
        end
        do_frame();
        check_val("t4_after_knock_x", bus.Enemy_X, 170);

        // 5: three accepted hits, invulnerability boundary, death and parking
        bus.action = 3'd0;
        do_spawn(10'd300, 10'd200);
        hit();
        check_val("t5_hit1_hp", bus.hp, 2);
        repeat (15) do_frame();
        hit();
        check_val("t5_frame15_hp", bus.hp, 2);
        check_val("t5_frame15_ack", bus.hit_ack, 0);
        do_frame();
        hit();
        check_val("t5_hit2_hp", bus.hp, 1);
        check_val("t5_hit2_ack", bus.hit_ack, 1);
        repeat (16) do_frame();
        hit();
        check_val("t5_hit3_hp", bus.hp, 0);
        check_val("t5_hit3_active", bus.active, 0);
        check_val("t5_hit3_ack", bus.hit_ack, 1);
        tick(1);
        check_val("t5_park_x", bus.Enemy_X, 700);
        check_val("t5_park_y", bus.Enemy_Y, 600);
        hit();
        check_val("t5_dead_ack", bus.hit_ack, 0);
        do_frame();
        do_frame();
        check_val("t5_dead_x", bus.Enemy_X, 700);
        check_val("t5_dead_y", bus.Enemy_Y, 600);
        check_val("t5_dead_active", bus.active, 0);

        // 6: room change during PROBE1 abandons the move; spawn with a room change wins
        bus.action = 3'd2;
        do_spawn(10'd100, 10'd100);
        @(negedge Clk);
        frame_clk = 1'b1;
        tick(4);
        bus.room = 3'd1;
        tick(1);
        check_val("t6_room_active", bus.active, 0);
        check_val("t6_room_hp", bus.hp, 0);
        check_val("t6_room_x", bus.Enemy_X, 700);
        tick(1);
        check_val("t6_nocommit_x", bus.Enemy_X, 700);
        frame_clk = 1'b0;
        tick(4);
        @(negedge Clk);
        bus.spawn   = 1'b1;
        bus.spawn_x = 10'd50;
        bus.spawn_y = 10'd60;
        bus.room    = 3'd2;
        @(negedge Clk);
        bus.spawn = 1'b0;
        check_val("t6_spawn_active", bus.active, 1);
        check_val("t6_spawn_hp", bus.hp, 3);
        check_val("t6_spawn_x", bus.Enemy_X, 50);
        tick(2);
        check_val("t6_settled_active", bus.active, 1);

        // 7: asynchronous reset in the middle of a probe
        @(negedge Clk);
        frame_clk = 1'b1;
        tick(3);
        #1;
        Reset_n = 1'b0;
        #1;
        check_val("t7_rst_x", bus.Enemy_X, 700);
        check_val("t7_rst_active", bus.active, 0);
        check_val("t7_rst_hp", bus.hp, 0);
        check_val("t7_rst_probe_x", bus.probe_x, 0);
        frame_clk = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        tick(2);
        check_val("t7_after_x", bus.Enemy_X, 700);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
